// File: rtl/decode_pipe.sv
// decode_pipe: instruction queue followed by a registered RV32I decode stage.
//
// A circular FIFO of IQ_DEPTH {instruction, pc} entries feeds a single output
// register stage that holds the decoded head instruction until the consumer
// accepts it. Minimum latency is two edges (push, then load into the output
// stage); throughput is one instruction per cycle while out_ready is high.
//
// Optional feature: define DECODE_RV32M_EN to decode the M extension
// (OP with funct7=0000001). Without it that encoding is illegal and
// out_muldiv is constant 0.
//
// Ports
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   flush                empties the queue and drops the staged instruction
//   in_valid/in_ready    fetch-side handshake, in_instruction/in_pc payload
//   out_valid/out_ready  decode-side handshake
//   out_pc, out_instruction, out_type ({j,u,s,b,i,r}), out_alu_op, out_imm,
//   out_rd_index, out_rs1_index, out_rs2_index, out_illegal, out_muldiv
//   iq_count             current queue occupancy
module decode_pipe #(
   parameter int unsigned IQ_DEPTH = 4,
   parameter int unsigned PC_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [31:0]                 in_instruction,
   input  logic [PC_WIDTH-1:0]         in_pc,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [PC_WIDTH-1:0]         out_pc,
   output logic [31:0]                 out_instruction,
   output logic [5:0]                  out_type,
   output logic [3:0]                  out_alu_op,
   output logic [31:0]                 out_imm,
   output logic [4:0]                  out_rd_index,
   output logic [4:0]                  out_rs1_index,
   output logic [4:0]                  out_rs2_index,
   output logic                        out_illegal,
   output logic                        out_muldiv,
   output logic [$clog2(IQ_DEPTH):0]   iq_count
);

   localparam int unsigned PtrW = $clog2(IQ_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [3:0] AluAdd   = 4'd0;
   localparam logic [3:0] AluSub   = 4'd1;
   localparam logic [3:0] AluSll   = 4'd2;
   localparam logic [3:0] AluSlt   = 4'd3;
   localparam logic [3:0] AluSltu  = 4'd4;
   localparam logic [3:0] AluXor   = 4'd5;
   localparam logic [3:0] AluSrl   = 4'd6;
   localparam logic [3:0] AluSra   = 4'd7;
   localparam logic [3:0] AluOr    = 4'd8;
   localparam logic [3:0] AluAnd   = 4'd9;
   localparam logic [3:0] AluPassB = 4'd10;

   localparam logic [5:0] TypeR = 6'b000001;
   localparam logic [5:0] TypeI = 6'b000010;
   localparam logic [5:0] TypeB = 6'b000100;
   localparam logic [5:0] TypeS = 6'b001000;
   localparam logic [5:0] TypeU = 6'b010000;
   localparam logic [5:0] TypeJ = 6'b100000;

   localparam logic [6:0] OpLui     = 7'b0110111;
   localparam logic [6:0] OpAuipc   = 7'b0010111;
   localparam logic [6:0] OpJal     = 7'b1101111;
   localparam logic [6:0] OpJalr    = 7'b1100111;
   localparam logic [6:0] OpBranch  = 7'b1100011;
   localparam logic [6:0] OpLoad    = 7'b0000011;
   localparam logic [6:0] OpStore   = 7'b0100011;
   localparam logic [6:0] OpImm     = 7'b0010011;
   localparam logic [6:0] OpReg     = 7'b0110011;
   localparam logic [6:0] OpMiscMem = 7'b0001111;
   localparam logic [6:0] OpSystem  = 7'b1110011;

   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
      logic [3:0] op;
      unique case (f3)
         3'b000:  op = AluAdd;
         3'b001:  op = AluSll;
         3'b010:  op = AluSlt;
         3'b011:  op = AluSltu;
         3'b100:  op = AluXor;
         3'b101:  op = AluSrl;
         3'b110:  op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

   // Queue state
   logic [31:0]         iq_inst_q [IQ_DEPTH];
   logic [31:0]         iq_inst_d [IQ_DEPTH];
   logic [PC_WIDTH-1:0] iq_pc_q   [IQ_DEPTH];
   logic [PC_WIDTH-1:0] iq_pc_d   [IQ_DEPTH];
   logic [PtrW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]     iq_count_q, iq_count_d;

   // Output stage state
   logic                out_valid_q, out_valid_d;
   logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
   logic [31:0]         out_inst_q, out_inst_d;
   logic [5:0]          out_type_q, out_type_d;
   logic [3:0]          out_alu_op_q, out_alu_op_d;
   logic [31:0]         out_imm_q, out_imm_d;
   logic [4:0]          out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
   logic                out_illegal_q, out_illegal_d;
   logic                out_muldiv_q, out_muldiv_d;

   logic push, pop;

   // Decoded view of the queue head
   logic [31:0] head_inst;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [5:0]  dec_type;
   logic [3:0]  dec_alu;
   logic [31:0] dec_imm;
   logic [4:0]  dec_rd, dec_rs1, dec_rs2;
   logic        dec_illegal, dec_muldiv;

   assign in_ready = (iq_count_q != CntW'(IQ_DEPTH)) && !flush;
   assign push     = in_valid && in_ready;
   // Output stage loads (and pops) whenever it is empty or being drained.
   assign pop      = (iq_count_q != '0) && (!out_valid_q || out_ready) && !flush;

   assign head_inst = iq_inst_q[rptr_q];
   assign f3        = head_inst[14:12];
   assign f7        = head_inst[31:25];
   assign imm_i     = {{20{head_inst[31]}}, head_inst[31:20]};
   assign imm_s     = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
   assign imm_b     = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0};
   assign imm_u     = {head_inst[31:12], 12'b0};
   assign imm_j     = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20], head_inst[30:21],
                       1'b0};

   always_comb begin
      dec_type    = '0;
      dec_alu     = AluAdd;
      dec_imm     = '0;
      dec_rd      = '0;
      dec_rs1     = '0;
      dec_rs2     = '0;
      dec_illegal = 1'b0;
      dec_muldiv  = 1'b0;
      if (head_inst[1:0] != 2'b11) begin
         dec_illegal = 1'b1;
      end else begin
         case (head_inst[6:0])
            OpLui: begin
               dec_type = TypeU; dec_alu = AluPassB; dec_imm = imm_u; dec_rd = head_inst[11:7];
            end
            OpAuipc: begin
               dec_type = TypeU; dec_imm = imm_u; dec_rd = head_inst[11:7];
            end
            OpJal: begin
               dec_type = TypeJ; dec_imm = imm_j; dec_rd = head_inst[11:7];
            end
            OpJalr: begin
               dec_type = TypeI; dec_imm = imm_i;
               dec_rd   = head_inst[11:7]; dec_rs1 = head_inst[19:15];
            end
            OpBranch: begin
               dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
               dec_type    = TypeB; dec_imm = imm_b;
               dec_rs1     = head_inst[19:15]; dec_rs2 = head_inst[24:20];
            end
            OpLoad: begin
               dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
               dec_type    = TypeI; dec_imm = imm_i;
               dec_rd      = head_inst[11:7]; dec_rs1 = head_inst[19:15];
            end
            OpStore: begin
               dec_illegal = (f3 >= 3'b011);
               dec_type    = TypeS; dec_imm = imm_s;
               dec_rs1     = head_inst[19:15]; dec_rs2 = head_inst[24:20];
            end
            OpImm: begin
               dec_type = TypeI; dec_imm = imm_i; dec_alu = alu_from_f3(f3);
               dec_rd   = head_inst[11:7]; dec_rs1 = head_inst[19:15];
               // Shift-immediates reuse the upper imm bits as a funct7 selector.
               if (f3 == 3'b001) begin
                  dec_illegal = (f7 != 7'b0000000);
               end else if (f3 == 3'b101) begin
                  if (f7 == 7'b0100000) dec_alu = AluSra;
                  else dec_illegal = (f7 != 7'b0000000);
               end
            end
            OpReg: begin
               dec_type = TypeR; dec_alu = alu_from_f3(f3);
               dec_rd   = head_inst[11:7]; dec_rs1 = head_inst[19:15];
               dec_rs2  = head_inst[24:20];
               if (f7 == 7'b0100000) begin
                  if (f3 == 3'b000)      dec_alu = AluSub;
                  else if (f3 == 3'b101) dec_alu = AluSra;
                  else                   dec_illegal = 1'b1;
               end else if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
                  dec_muldiv = 1'b1;
                  dec_alu    = {1'b0, f3};
`else
                  dec_illegal = 1'b1;
`endif
               end else if (f7 != 7'b0000000) begin
                  dec_illegal = 1'b1;
               end
            end
            OpMiscMem: begin
               dec_illegal = (f3 != 3'b000) && (f3 != 3'b001);
               dec_type    = TypeI; dec_imm = imm_i;
               dec_rd      = head_inst[11:7]; dec_rs1 = head_inst[19:15];
            end
            OpSystem: begin
               dec_type = TypeI; dec_imm = imm_i;
               dec_rd   = head_inst[11:7]; dec_rs1 = head_inst[19:15];
               // funct3=000 is only ECALL/EBREAK: imm 0 or 1, rs1 and rd zero.
               if (f3 == 3'b100) begin
                  dec_illegal = 1'b1;
               end else if (f3 == 3'b000) begin
                  dec_illegal = (head_inst[31:21] != '0) || (head_inst[19:7] != '0);
               end
            end
            default: dec_illegal = 1'b1;
         endcase
      end
      // Illegal words flow through with every decoded field zeroed.
      if (dec_illegal) begin
         dec_type   = '0;
         dec_alu    = AluAdd;
         dec_imm    = '0;
         dec_rd     = '0;
         dec_rs1    = '0;
         dec_rs2    = '0;
         dec_muldiv = 1'b0;
      end
   end

   always_comb begin
      iq_inst_d  = iq_inst_q;
      iq_pc_d    = iq_pc_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      iq_count_d = iq_count_q;
      if (flush) begin
         wptr_d     = '0;
         rptr_d     = '0;
         iq_count_d = '0;
      end else begin
         if (push) begin
            iq_inst_d[wptr_q] = in_instruction;
            iq_pc_d[wptr_q]   = in_pc;
            wptr_d            = wptr_q + PtrW'(1);
         end
         if (pop) rptr_d = rptr_q + PtrW'(1);
         if (push && !pop)      iq_count_d = iq_count_q + CntW'(1);
         else if (pop && !push) iq_count_d = iq_count_q - CntW'(1);
      end
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_inst_d    = out_inst_q;
      out_type_d    = out_type_q;
      out_alu_op_d  = out_alu_op_q;
      out_imm_d     = out_imm_q;
      out_rd_d      = out_rd_q;
      out_rs1_d     = out_rs1_q;
      out_rs2_d     = out_rs2_q;
      out_illegal_d = out_illegal_q;
      out_muldiv_d  = out_muldiv_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (pop) begin
         out_valid_d   = 1'b1;
         out_pc_d      = iq_pc_q[rptr_q];
         out_inst_d    = head_inst;
         out_type_d    = dec_type;
         out_alu_op_d  = dec_alu;
         out_imm_d     = dec_imm;
         out_rd_d      = dec_rd;
         out_rs1_d     = dec_rs1;
         out_rs2_d     = dec_rs2;
         out_illegal_d = dec_illegal;
         out_muldiv_d  = dec_muldiv;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IQ_DEPTH; i++) begin
            iq_inst_q[i] <= '0;
            iq_pc_q[i]   <= '0;
         end
         wptr_q        <= '0;
         rptr_q        <= '0;
         iq_count_q    <= '0;
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_inst_q    <= '0;
         out_type_q    <= '0;
         out_alu_op_q  <= '0;
         out_imm_q     <= '0;
         out_rd_q      <= '0;
         out_rs1_q     <= '0;
         out_rs2_q     <= '0;
         out_illegal_q <= 1'b0;
         out_muldiv_q  <= 1'b0;
      end else begin
         iq_inst_q     <= iq_inst_d;
         iq_pc_q       <= iq_pc_d;
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         iq_count_q    <= iq_count_d;
         out_valid_q   <= out_valid_d;
         out_pc_q      <= out_pc_d;
         out_inst_q    <= out_inst_d;
         out_type_q    <= out_type_d;
         out_alu_op_q  <= out_alu_op_d;
         out_imm_q     <= out_imm_d;
         out_rd_q      <= out_rd_d;
         out_rs1_q     <= out_rs1_d;
         out_rs2_q     <= out_rs2_d;
         out_illegal_q <= out_illegal_d;
         out_muldiv_q  <= out_muldiv_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_pc          = out_pc_q;
   assign out_instruction = out_inst_q;
   assign out_type        = out_type_q;
   assign out_alu_op      = out_alu_op_q;
   assign out_imm         = out_imm_q;
   assign out_rd_index    = out_rd_q;
   assign out_rs1_index   = out_rs1_q;
   assign out_rs2_index   = out_rs2_q;
   assign out_illegal     = out_illegal_q;
   assign out_muldiv      = out_muldiv_q;
   assign iq_count        = iq_count_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed bench for decode_pipe (IQ_DEPTH=4, PC_WIDTH=32).
// Covers reset values, two-edge latency, back-to-back decode of several
// formats, queue-full back-pressure, flush, and asynchronous reset.
module tb_decode_pipe;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instruction, in_pc, out_pc, out_instruction, out_imm;
   logic [5:0]  out_type;
   logic [3:0]  out_alu_op;
   logic [4:0]  out_rd_index, out_rs1_index, out_rs2_index;
   logic        out_illegal, out_muldiv;
   logic [2:0]  iq_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decode_pipe #(.IQ_DEPTH(4), .PC_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instruction(out_instruction),
      .out_type(out_type), .out_alu_op(out_alu_op), .out_imm(out_imm),
      .out_rd_index(out_rd_index), .out_rs1_index(out_rs1_index),
      .out_rs2_index(out_rs2_index),
      .out_illegal(out_illegal), .out_muldiv(out_muldiv),
      .iq_count(iq_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [5:0] typ, input logic [3:0] alu,
                            input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic ill, input logic md);
      check({tag, ".valid"}, out_valid, 1'b1);
      check({tag, ".type"}, out_type, typ);
      check({tag, ".alu"}, out_alu_op, alu);
      check({tag, ".imm"}, out_imm, imm);
      check({tag, ".rd"}, out_rd_index, rd);
      check({tag, ".rs1"}, out_rs1_index, rs1);
      check({tag, ".rs2"}, out_rs2_index, rs2);
      check({tag, ".illegal"}, out_illegal, ill);
      check({tag, ".muldiv"}, out_muldiv, md);
   endtask

   function automatic logic [31:0] addi_n(input int n);
      return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
   endfunction

   initial begin
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instruction = '0; in_pc = '0;
      out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("rst.out_valid", out_valid, 1'b0);
      check("rst.iq_count", iq_count, 3'd0);
      check("rst.illegal", out_illegal, 1'b0);
      check("rst.muldiv", out_muldiv, 1'b0);
      check("rst.type", out_type, 6'd0);
      check("rst.pc", out_pc, 32'd0);
      check("rst.in_ready", in_ready, 1'b1);

      // addi x1,x0,5 into an empty pipe: valid two edges after offering
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b1; in_instruction = 32'h00500093; in_pc = 32'h100;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("lat.edge1.valid", out_valid, 1'b0);
      check("lat.edge1.count", iq_count, 3'd1);
      tick();
      check_out("addi", 6'b000010, 4'd0, 32'd5, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      check("addi.pc", out_pc, 32'h100);
      check("addi.inst", out_instruction, 32'h00500093);
      tick();
      check("empty_drain.valid", out_valid, 1'b0);

      // Back-to-back stream, one per cycle with out_ready=1
      in_valid = 1'b1; in_instruction = 32'h402081B3; in_pc = 32'h200;    // sub
      tick();
      in_instruction = 32'hFE000EE3; in_pc = 32'h204;                     // beq x0,x0,-4
      tick();
      check_out("sub", 6'b000001, 4'd1, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
      check("sub.pc", out_pc, 32'h200);
      check("stream.count", iq_count, 3'd1);
      in_instruction = 32'h022081B3; in_pc = 32'h208;                     // mul
      tick();
      check_out("beq", 6'b000100, 4'd0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      in_instruction = 32'h123452B7; in_pc = 32'h20C;                     // lui x5,0x12345
      tick();
`ifdef DECODE_RV32M_EN
      check_out("mul", 6'b000001, 4'd0, 32'd0, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1);
`else
      check("mul.illegal", out_illegal, 1'b1);
      check("mul.type", out_type, 6'd0);
      check("mul.muldiv", out_muldiv, 1'b0);
      check("mul.rd", out_rd_index, 5'd0);
`endif
      check("mul.pc", out_pc, 32'h208);
      in_instruction = 32'h008000EF; in_pc = 32'h210;                     // jal x1,8
      tick();
      check_out("lui", 6'b010000, 4'd10, 32'h12345000, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      in_instruction = 32'h0020A623; in_pc = 32'h214;                     // sw x2,12(x1)
      tick();
      check_out("jal", 6'b100000, 4'd0, 32'd8, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      in_instruction = 32'h4030D093; in_pc = 32'h218;                     // srai x1,x1,3
      tick();
      check_out("sw", 6'b001000, 4'd0, 32'd12, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
      in_instruction = 32'h00000000; in_pc = 32'h21C;                     // all-zero word
      tick();
      check_out("srai", 6'b000010, 4'd7, 32'h403, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0);
      in_instruction = 32'h0000B083; in_pc = 32'h220;                     // load funct3=011
      tick();
      check_out("zero", 6'd0, 4'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      in_valid = 1'b0;
      tick();
      check_out("ld_bad", 6'd0, 4'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      check("ld_bad.pc", out_pc, 32'h220);
      tick();
      check("stream_end.valid", out_valid, 1'b0);

      // Back-pressure: 6 offered, 5 accepted (4 queued + 1 staged)
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_instruction = addi_n(i + 1); in_pc = 32'h300 + 32'(4 * i);
         check($sformatf("full.in_ready%0d", i), in_ready, (i < 5) ? 1'b1 : 1'b0);
         tick();
         if (i >= 1) check($sformatf("full.hold_pc%0d", i), out_pc, 32'h300);
      end
      in_valid = 1'b0;
      check("full.count", iq_count, 3'd4);
      check("full.in_ready", in_ready, 1'b0);
      check("full.valid", out_valid, 1'b1);
      check("full.hold_rd", out_rd_index, 5'd1);
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         check($sformatf("drain%0d.valid", i), out_valid, 1'b1);
         check($sformatf("drain%0d.pc", i), out_pc, 32'h300 + 32'(4 * i));
         check($sformatf("drain%0d.imm", i), out_imm, 32'(i + 1));
         check($sformatf("drain%0d.count", i), iq_count, 3'(4 - i));
      end
      tick();
      check("drain_end.valid", out_valid, 1'b0);

      // Flush with 3 queued and 1 staged; push offered during flush is dropped
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_instruction = addi_n(i + 1); in_pc = 32'h400 + 32'(4 * i);
         tick();
      end
      check("preflush.count", iq_count, 3'd3);
      check("preflush.valid", out_valid, 1'b1);
      flush = 1'b1; in_valid = 1'b1; in_instruction = addi_n(9); in_pc = 32'h4F0;
      #1;
      check("flush.in_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush.valid", out_valid, 1'b0);
      check("flush.count", iq_count, 3'd0);
      tick();
      check("flush.dropped_push", iq_count, 3'd0);
      in_valid = 1'b1; in_instruction = addi_n(7); in_pc = 32'h500;
      tick();
      in_valid = 1'b0;
      check("postflush.count", iq_count, 3'd1);
      out_ready = 1'b1;
      tick();
      check("postflush.valid", out_valid, 1'b1);
      check("postflush.pc", out_pc, 32'h500);
      check("postflush.imm", out_imm, 32'd7);

      // Asynchronous reset mid-transfer clears state without a clock edge
      out_ready = 1'b0;
      in_valid = 1'b1; in_instruction = addi_n(2); in_pc = 32'h600;
      tick();
      check("arst.pre_count", iq_count, 3'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst.valid", out_valid, 1'b0);
      check("arst.count", iq_count, 3'd0);
      check("arst.pc", out_pc, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst.after_valid", out_valid, 1'b0);
      check("arst.after_count", iq_count, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter PC_WIDTH, default 32, width of the carried PC.
REQ-003 SHALL have `clk`, input, 1 bit: the single clock; every flop uses its rising edge.
REQ-004 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have `flush`, input, 1 bit: discard all queued and staged instructions.
REQ-006 SHALL have `in_valid`, input, 1 bit: the fetch side offers an instruction.
REQ-007 SHALL have `in_ready`, output, 1 bit: the queue can accept an instruction.
REQ-008 SHALL have `in_instruction`, input, 32 bits, and `in_pc`, input, PC_WIDTH bits: the instruction word and its PC.
REQ-009 SHALL have `out_valid`, output, 1 bit, and `out_ready`, input, 1 bit: decoded-output handshake.
REQ-010 SHALL have `out_pc`, output, PC_WIDTH bits, and `out_instruction`, output, 32 bits: the PC and raw word of the staged instruction.
REQ-011 SHALL have `out_type`, output, 6 bits: one-hot format class {j,u,s,b,i,r}, bit 0 = r.
REQ-012 SHALL have `out_alu_op`, output, 4 bits, with this encoding:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- Loads, stores, branch-target and AUIPC use ADD; LUI uses PASSB.
REQ-013 SHALL have `out_imm`, output, 32 bits: sign-extended immediate for the decoded format; 0 for R-type.
REQ-014 SHALL have `out_rd_index`, `out_rs1_index` and `out_rs2_index`, each output, 5 bits: register fields; each is 0 when the format does not use it.
REQ-015 SHALL have `out_illegal`, output, 1 bit, and `out_muldiv`, output, 1 bit.
REQ-016 SHALL have `iq_count`, output, $clog2(IQ_DEPTH)+1 bits: current queue occupancy.

Function
REQ-017 The queue SHALL be a circular FIFO holding {instruction, pc}; read and write pointers wrap modulo IQ_DEPTH.
REQ-018 `in_ready` SHALL equal (iq_count != IQ_DEPTH) AND NOT flush; there is no push-while-full bypass.
REQ-019 A push SHALL occur on an edge where in_valid AND in_ready; simultaneous push and pop SHALL leave iq_count unchanged.
REQ-020 The output stage SHALL load the decoded queue head on an edge where the queue is non-empty AND (NOT out_valid OR out_ready); that load pops the queue.
REQ-021 Minimum latency SHALL be 2 edges: an instruction pushed at edge k into an empty pipe gives out_valid=1 after edge k+1.
REQ-022 Sustained throughput SHALL be 1 instruction per cycle while out_ready=1.
REQ-023 Output fields SHALL be registered and held stable while out_valid=1 AND out_ready=0.
REQ-024 When out_ready=1 and the queue is empty, out_valid SHALL drop to 0 on the next edge.
REQ-025 Decode SHALL cover all RV32I opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (FENCE, FENCE.I) and SYSTEM (ECALL, EBREAK, CSR*).
REQ-026 out_illegal SHALL be 1 for any of:
- an unknown opcode, or low two bits != 11;
- a reserved funct3 (BRANCH 010/011, LOAD 011/110/111, STORE >= 011);
- a bad funct7 (OP other than 0000000/0100000, SLLI/SRLI/SRAI field violations);
- the all-zero word.
REQ-027 Illegal instructions SHALL still flow through the pipe with out_type=0, out_alu_op=0 and out_imm=0.
REQ-028 Immediate formats SHALL be:
- I = inst[31:20];
- S = {inst[31:25], inst[11:7]};
- B = {inst[31], inst[7], inst[30:25], inst[11:8], 0};
- U = {inst[31:12], 12'b0};
- J = {inst[31], inst[19:12], inst[20], inst[30:21], 0};
- all sign-extended from bit 31.
REQ-029 A flush on edge k SHALL empty the queue (iq_count=0, pointers=0) and clear out_valid.
REQ-030 A push or pop offered during a flush cycle SHALL be discarded.
REQ-031 When flush=0 again, a push SHALL proceed normally.

Reset
REQ-032 While rst_n=0, pointers, iq_count, out_valid, out_illegal and out_muldiv SHALL be 0, and all other out_* registers SHALL be 0.
REQ-033 rst_n assertion mid-transfer SHALL discard all in-flight instructions immediately, without waiting for a clock edge.
REQ-034 Release of rst_n SHALL take effect at the first rising edge of `clk` after it.

Configuration
REQ-035 Macro DECODE_RV32M_EN SHALL select M-extension decoding.
- Defined: OP with funct7=0000001 is legal, out_muldiv=1, out_alu_op=funct3, out_type=r.
- Undefined: that encoding sets out_illegal=1 and out_muldiv is constant 0.

Verification
REQ-036 The bench SHALL cover addi x1,x0,5 (0x00500093) pushed into an empty pipe: 2 edges later out_valid=1, out_type=000010, rd=1, rs1=0, out_imm=0x00000005, alu_op=0.
REQ-037 The bench SHALL cover sub x3,x1,x2 (0x402081B3): out_type=000001, alu_op=1, rd=3, rs1=1, rs2=2, out_imm=0.
REQ-038 The bench SHALL cover beq x0,x0,-4 (0xFE000EE3): out_type=000100, out_imm=0xFFFFFFFC, rd=0.
REQ-039 The bench SHALL cover mul x3,x1,x2 (0x022081B3): with DECODE_RV32M_EN, out_muldiv=1 and alu_op=0; without it, out_illegal=1.
REQ-040 The bench SHALL cover IQ_DEPTH=4 with out_ready=0 and 6 pushes offered: 5 accepted (4 queued + 1 staged), in_ready=0 and iq_count=4; then out_ready=1 drains the instructions in order.
REQ-041 The bench SHALL cover flush asserted with 3 queued and 1 staged: next cycle out_valid=0, iq_count=0; the push offered during the flush cycle is not accepted.
